// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a per-register busy scoreboard.
// After reset, a sweep clears the registers one per cycle. It then sets ready and accepts traffic.
// Register 0 always reads 0 and is never busy.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle writeback onto the read
// ports. Forwarding also clears the busy flag that the read port shows.
module regfile_sb #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic            write_en,
    input  logic [AW-1:0]   write_reg,
    input  logic [XLEN-1:0] write_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_reg,
    input  logic [AW-1:0]   read_reg_a,
    input  logic [AW-1:0]   read_reg_b,
    output logic [XLEN-1:0] reg_a_data,
    output logic [XLEN-1:0] reg_b_data,
    output logic            reg_a_busy,
    output logic            reg_b_busy
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    localparam logic [AW:0] LastReg = (AW + 1)'(NREGS - 1);
    localparam logic [AW:0] CntOne  = (AW + 1)'(1);

    state_e            state;
    logic [AW:0]       sweep_cnt;
    logic [NREGS-1:0]  busy;
    logic [XLEN-1:0]   regs [NREGS];

    logic              run;
    logic              wr_ok;
    logic              iss_ok;
    logic              file_we;
    logic [AW-1:0]     file_addr;
    logic [XLEN-1:0]   file_data;

    assign run    = (state == StRun);
    assign wr_ok  = run && write_en && (write_reg != '0);
    assign iss_ok = run && issue_en && (issue_reg != '0);

    // Single write port: the sweep zeroes entries while clearing, and writeback uses it in RUN.
    always_comb begin
        file_we   = 1'b0;
        file_addr = write_reg;
        file_data = write_data;
        if (!run) begin
            file_we   = !rst;
            file_addr = sweep_cnt[AW-1:0];
            file_data = '0;
        end else if (wr_ok && !rst) begin
            file_we = 1'b1;
        end
    end

    // Storage array. It has no reset; the sweep provides the defined contents.
    always_ff @(posedge clk) begin
        if (file_we) begin
            regs[file_addr] <= file_data;
        end
    end

    // Clear/run sequencer and scoreboard. In RUN, an issue overrides a same-cycle writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StClear;
            sweep_cnt <= '0;
            busy      <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                StClear: begin
                    sweep_cnt <= sweep_cnt + CntOne;
                    if (sweep_cnt == LastReg) begin
                        state <= StRun;
                        ready <= 1'b1;
                    end
                end
                StRun: begin
                    if (wr_ok) begin
                        busy[write_reg] <= 1'b0;
                    end
                    if (iss_ok) begin
                        busy[issue_reg] <= 1'b1;
                    end
                end
                default: state <= StClear;
            endcase
        end
    end

    // Read port A. Outside RUN, and for x0, the port returns zero and not busy.
    always_comb begin
        reg_a_data = '0;
        reg_a_busy = 1'b0;
        if (run && (read_reg_a != '0)) begin
            reg_a_data = regs[read_reg_a];
            reg_a_busy = busy[read_reg_a];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (write_reg == read_reg_a)) begin
                reg_a_data = write_data;
                reg_a_busy = 1'b0;
            end
`endif
        end
    end

    // Read port B. It works the same way as port A.
    always_comb begin
        reg_b_data = '0;
        reg_b_busy = 1'b0;
        if (run && (read_reg_b != '0)) begin
            reg_b_data = regs[read_reg_b];
            reg_b_busy = busy[read_reg_b];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (write_reg == read_reg_b)) begin
                reg_b_data = write_data;
                reg_b_busy = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb. It checks the default RV64 build and the RV32E build against an
// array model.
module tb_regfile_sb;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ready;
    logic            write_en = 1'b0;
    logic [AW-1:0]   write_reg = '0;
    logic [XLEN-1:0] write_data = '0;
    logic            issue_en = 1'b0;
    logic [AW-1:0]   issue_reg = '0;
    logic [AW-1:0]   read_reg_a = '0;
    logic [AW-1:0]   read_reg_b = '0;
    logic [XLEN-1:0] reg_a_data, reg_b_data;
    logic            reg_a_busy, reg_b_busy;

    // E-variant instance signals
    logic            e_rst = 1'b1;
    logic            e_ready;
    logic            e_we = 1'b0;
    logic [3:0]      e_wr = '0;
    logic [31:0]     e_wd = '0;
    logic            e_ie = 1'b0;
    logic [3:0]      e_ir = '0;
    logic [3:0]      e_ra = '0;
    logic [3:0]      e_rb = '0;
    logic [31:0]     e_a_data, e_b_data;
    logic            e_a_busy, e_b_busy;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] mdl   [NREGS];
    logic            mbusy [NREGS];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
        .issue_en(issue_en), .issue_reg(issue_reg),
        .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
        .reg_a_data(reg_a_data), .reg_b_data(reg_b_data),
        .reg_a_busy(reg_a_busy), .reg_b_busy(reg_b_busy)
    );

    regfile_sb #(.XLEN(32), .NREGS(16)) dut_e (
        .clk(clk), .rst(e_rst), .ready(e_ready),
        .write_en(e_we), .write_reg(e_wr), .write_data(e_wd),
        .issue_en(e_ie), .issue_reg(e_ir),
        .read_reg_a(e_ra), .read_reg_b(e_rb),
        .reg_a_data(e_a_data), .reg_b_data(e_b_data),
        .reg_a_busy(e_a_busy), .reg_b_busy(e_b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // After a completed sweep, every register holds zero and nothing is pending.
    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mdl[i]   = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    // One RUN cycle. It drives the inputs and checks the reads against the model before the edge.
    // After the edge it applies the writeback and issue rules to the model.
    task automatic cyc(input logic we, input logic [AW-1:0] wr, input logic [XLEN-1:0] wd,
                       input logic ie, input logic [AW-1:0] ir,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb, input string tag);
        logic [XLEN-1:0] ea, eb;
        logic            ba, bb;
        write_en = we; write_reg = wr; write_data = wd;
        issue_en = ie; issue_reg = ir;
        read_reg_a = ra; read_reg_b = rb;
        #1;
        ea = mdl[ra]; ba = mbusy[ra];
        eb = mdl[rb]; bb = mbusy[rb];
`ifdef REGFILE_BYPASS_EN
        if (we && wr != 0 && wr == ra) begin ea = wd; ba = 1'b0; end
        if (we && wr != 0 && wr == rb) begin eb = wd; bb = 1'b0; end
`endif
        chk({tag, "_a_data"}, reg_a_data, ea);
        chk({tag, "_a_busy"}, reg_a_busy, ba);
        chk({tag, "_b_data"}, reg_b_data, eb);
        chk({tag, "_b_busy"}, reg_b_busy, bb);
        @(posedge clk);
        #1;
        if (we && wr != 0) begin mdl[wr] = wd; mbusy[wr] = 1'b0; end
        if (ie && ir != 0) mbusy[ir] = 1'b1;
        write_en = 1'b0;
        issue_en = 1'b0;
    endtask

    // Holds reset for a number of edges and runs the sweep while checking ready on each edge.
    // A write to x5 is attempted on sweep cycle 3.
    task automatic sweep_main(input int hold);
        rst = 1'b1;
        write_en = 1'b0; issue_en = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", reg_a_busy, 1'b0);
        rst = 1'b0;
        for (int n = 1; n <= NREGS; n++) begin
            read_reg_a = AW'(n);
            write_en   = (n == 3);
            write_reg  = 5'd5;
            write_data = 64'hAA;
            issue_en   = (n == 3);
            issue_reg  = 5'd5;
            #1;
            chk("sweep_rd_zero", reg_a_data, 64'h0);
            chk("sweep_busy_zero", reg_a_busy, 1'b0);
            @(posedge clk);
            #1;
            chk("sweep_ready", ready, (n == NREGS));
        end
        write_en = 1'b0;
        issue_en = 1'b0;
        model_reset();
    endtask

    initial begin
        sweep_main(2);
        cyc(0, 0, 0, 0, 0, 5, 5, "x5_after_sweep");
        chk("x5_zero_lit", reg_a_data, 64'h0);

        // Basic write and read, and writes to x0
        cyc(1, 7, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0, "wr_x7");
        cyc(0, 0, 0, 0, 0, 7, 0, "rd_x7");
        chk("x7_lit", reg_a_data, 64'hDEAD_BEEF_0123_4567);
        cyc(1, 0, '1, 1, 0, 0, 0, "wr_x0");
        cyc(0, 0, 0, 0, 0, 0, 0, "rd_x0");
        chk("x0_lit", reg_a_data, 64'h0);
        chk("x0_busy_lit", reg_a_busy, 1'b0);

        // Scoreboard
        cyc(0, 0, 0, 1, 3, 3, 0, "iss_x3");
        cyc(0, 0, 0, 0, 0, 3, 0, "rd_x3_busy");
        chk("x3_busy_lit", reg_a_busy, 1'b1);
        cyc(1, 3, 64'h10, 0, 0, 3, 0, "wr_x3");
        cyc(0, 0, 0, 0, 0, 3, 0, "rd_x3_free");
        chk("x3_free_lit", reg_a_busy, 1'b0);
        cyc(1, 3, 64'h10, 1, 3, 0, 0, "coll_x3");
        cyc(0, 0, 0, 0, 0, 3, 0, "rd_x3_coll");
        chk("x3_coll_data_lit", reg_a_data, 64'h10);
        chk("x3_coll_busy_lit", reg_a_busy, 1'b1);

        // Same-cycle write versus read; the expectation depends on the bypass build
        cyc(1, 9, 64'h33, 0, 0, 0, 0, "pre_x9");
        cyc(0, 0, 0, 1, 9, 0, 0, "iss_x9");
        cyc(1, 9, 64'h55, 0, 0, 0, 9, "byp_x9");
        cyc(0, 0, 0, 0, 0, 0, 9, "rd_x9");
        chk("x9_lit", reg_b_data, 64'h55);

        // Random traffic over a small register window so that collisions are frequent
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 1), AW'($urandom_range(0, 7)), {$urandom, $urandom},
                $urandom_range(0, 1), AW'($urandom_range(0, 7)),
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)), "rand");
        end

        // Reset during operation
        cyc(1, 4, 64'h99, 0, 0, 0, 0, "wr_x4");
        cyc(0, 0, 0, 1, 4, 4, 0, "iss_x4");
        cyc(0, 0, 0, 0, 0, 4, 0, "rd_x4");
        chk("x4_busy_lit", reg_a_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", ready, 1'b0);
        chk("mid_rst_busy", reg_a_busy, 1'b0);
        chk("mid_rst_data", reg_a_data, 64'h0);
        sweep_main(1);
        cyc(0, 0, 0, 0, 0, 4, 4, "x4_after_resweep");
        chk("x4_resweep_lit", reg_a_data, 64'h0);

        // E variant: 16 registers of 32 bits
        e_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("e_rst_ready", e_ready, 1'b0);
        e_rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            chk("e_sweep_ready", e_ready, (n == 16));
        end
        e_we = 1'b1; e_wr = 4'd15; e_wd = 32'h8000_0001;
        @(posedge clk);
        #1;
        e_we = 1'b0; e_ra = 4'd15; e_rb = 4'd0;
        #1;
        chk("e_x15", e_a_data, 32'h8000_0001);
        chk("e_x15_busy", e_a_busy, 1'b0);
        chk("e_x0", e_b_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
